// File: rtl/kernel_pkg.sv
// +----------------------------------------------------------------------------+
// | kernel_pkg: shared types for the 3x3 kernel window loader                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package kernel_pkg;

  localparam int PIX_W = 8;
  localparam int WIN   = 3;

  typedef logic [WIN*PIX_W-1:0] row_t;
  typedef row_t window_t [0:WIN-1];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    VALID = 2'd3
  } kwl_state_t;

  typedef enum logic {
    FULL  = 1'b0,
    SLIDE = 1'b1
  } kwl_mode_t;

  // Row-major window index 0..8 split into row and column.
  function automatic logic [1:0] idx_row(input logic [3:0] idx);
    logic [1:0] r;
    if (idx < 4'd3)      r = 2'd0;
    else if (idx < 4'd6) r = 2'd1;
    else                 r = 2'd2;
    return r;
  endfunction

  function automatic logic [1:0] idx_col(input logic [3:0] idx);
    logic [1:0] c;
    case (idx)
      4'd0, 4'd3, 4'd6: c = 2'd0;
      4'd1, 4'd4, 4'd7: c = 2'd1;
      default:          c = 2'd2;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kernel_addr_gen.sv
// +----------------------------------------------------------------------------+
// | kernel_addr_gen: walks window read addresses with incremental row offsets  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module kernel_addr_gen
  import kernel_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              slide_load,
  input  logic              step,
  input  kwl_mode_t         mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] mem_addr
);

  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_stride;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_col;
  logic [ADDR_W-1:0] w_next_row;

  assign w_next_row = r_row_base + r_stride;
  assign mem_addr   = r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur      <= '0;
      r_stride   <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
      r_col      <= 2'd0;
    end else if (load) begin
      r_cur      <= base_addr;
      r_stride   <= stride;
      r_row_base <= base_addr;
      r_addr     <= base_addr;
      r_col      <= 2'd0;
    end else if (slide_load) begin
      // New column sits at (cur+1)+2; only the rightmost pixel of each row is read.
      r_cur      <= r_cur + ADDR_W'(1);
      r_row_base <= r_cur + ADDR_W'(3);
      r_addr     <= r_cur + ADDR_W'(3);
      r_col      <= 2'd0;
    end else if (step) begin
      if (mode == SLIDE) begin
        r_row_base <= w_next_row;
        r_addr     <= w_next_row;
      end else if (r_col == 2'd2) begin
        r_col      <= 2'd0;
        r_row_base <= w_next_row;
        r_addr     <= w_next_row;
      end else begin
        r_col      <= r_col + 2'd1;
        r_addr     <= r_addr + ADDR_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/kernel_window_loader.sv
// +----------------------------------------------------------------------------+
// | kernel_window_loader: fetches a 3x3 pixel window into a valid/ack cache    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module kernel_window_loader
  import kernel_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              slide,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output window_t           cache,
  output logic              valid,
  input  logic              ack,
  output logic              busy
);

  kwl_state_t r_state;
  kwl_mode_t  r_mode;
  logic [3:0] r_idx;
  logic       r_rd;
  logic       r_cap_vld;
  logic [3:0] r_cap_idx;
  window_t    r_cache;

  logic       w_last;
  logic       w_load;
  logic       w_slide_load;
  logic       w_step;
  logic [1:0] w_cap_row;
  logic [4:0] w_cap_lsb;

  assign w_last       = (r_idx == ((r_mode == FULL) ? 4'd8 : 4'd2));
  assign w_load       = start && ((r_state == IDLE) || (r_state == VALID));
  assign w_slide_load = slide && !start && (r_state == VALID);
  assign w_step       = (r_state == FETCH) && !w_last;

  assign mem_rd = r_rd;
  assign valid  = (r_state == VALID);
  assign busy   = (r_state == FETCH) || (r_state == DRAIN);
  assign cache  = r_cache;

  kernel_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .slide_load (w_slide_load),
    .step       (w_step),
    .mode       (r_mode),
    .base_addr  (base_addr),
    .stride     (stride),
    .mem_addr   (mem_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= FULL;
      r_idx   <= 4'd0;
      r_rd    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= FETCH;
            r_mode  <= FULL;
            r_idx   <= 4'd0;
            r_rd    <= 1'b1;
          end
        end
        FETCH: begin
          if (w_last) begin
            r_state <= DRAIN;
            r_rd    <= 1'b0;
          end else begin
            r_idx   <= r_idx + 4'd1;
          end
        end
        DRAIN: r_state <= VALID;
        VALID: begin
          if (start) begin
            r_state <= FETCH;
            r_mode  <= FULL;
            r_idx   <= 4'd0;
            r_rd    <= 1'b1;
          end else if (slide) begin
            r_state <= FETCH;
            r_mode  <= SLIDE;
            r_idx   <= 4'd0;
            r_rd    <= 1'b1;
          end else if (ack) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read data lands one cycle after the strobe, so capture follows a delayed index.
  always_comb begin
    w_cap_row = idx_row(r_cap_idx);
    case (idx_col(r_cap_idx))
      2'd0:    w_cap_lsb = 5'd16;
      2'd1:    w_cap_lsb = 5'd8;
      default: w_cap_lsb = 5'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_vld <= 1'b0;
      r_cap_idx <= 4'd0;
      for (int i = 0; i < WIN; i++) begin
        r_cache[i] <= '0;
      end
    end else begin
      r_cap_vld <= r_rd;
      r_cap_idx <= r_idx;
      if (r_cap_vld) begin
        if (r_mode == FULL) begin
          r_cache[w_cap_row][w_cap_lsb +: PIX_W] <= mem_rdata;
        end else begin
          r_cache[r_cap_idx[1:0]] <= {r_cache[r_cap_idx[1:0]][2*PIX_W-1:0], mem_rdata};
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_kernel_window_loader.sv
// +----------------------------------------------------------------------------+
// | tb_kernel_window_loader: scoreboard bench for the kernel window loader     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_kernel_window_loader;
  import kernel_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        slide;
  logic [15:0] base_addr;
  logic [15:0] stride;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  row_t        cache [0:2];
  logic        valid;
  logic        ack;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q [$];
  logic [23:0] m_win [3];
  logic [15:0] m_cur;
  logic [15:0] m_stride;

  kernel_window_loader #(.ADDR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .slide     (slide),
    .base_addr (base_addr),
    .stride    (stride),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .cache     (cache),
    .valid     (valid),
    .ack       (ack),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem_addr[7:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every read strobe must match the next address the model predicted.
  always @(negedge clk) begin
    if (mem_rd) begin
      check("rd_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("rd_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
    end
  end

  task automatic push_full(input logic [15:0] b, input logic [15:0] s, input int n);
    logic [15:0] a;
    m_cur    = b;
    m_stride = s;
    for (int i = 0; i < 9; i++) begin
      a = b + 16'(i / 3) * s + 16'(i % 3);
      if (i < n) exp_q.push_back(a);
      m_win[i / 3][(2 - i % 3) * 8 +: 8] = a[7:0];
    end
  endtask

  task automatic push_slide();
    logic [15:0] a;
    m_cur = m_cur + 16'd1;
    for (int i = 0; i < 3; i++) begin
      a = m_cur + 16'd2 + 16'(i) * m_stride;
      exp_q.push_back(a);
      m_win[i] = {m_win[i][15:0], a[7:0]};
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic st, input logic sl, input logic ak,
                       input logic [15:0] b, input logic [15:0] s);
    start     = st;
    slide     = sl;
    ack       = ak;
    base_addr = b;
    stride    = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    slide = 1'b0;
    ack   = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_cyc);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, "_busy_c1"}, 32'(busy), 32'd1);
      if (valid) begin
        check({tag, "_latency"}, 32'(c), 32'(exp_cyc));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        return;
      end
    end
    check({tag, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_win(input string tag);
    for (int r = 0; r < 3; r++) begin
      check($sformatf("%s_row%0d", tag, r), 32'(cache[r]), 32'(m_win[r]));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; slide = 1'b0; ack = 1'b0;
    base_addr = '0; stride = '0;
    for (int r = 0; r < 3; r++) m_win[r] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_win("rst");
    sync();

    // Full load
    push_full(16'h0100, 16'd16, 9);
    do_op(1, 0, 0, 16'h0100, 16'd16);
    wait_valid("t1", 11);
    check_win("t1");
    check("t1_row0_const", 32'(cache[0]), 32'h000102);
    sync();

    // Slide, then ack back to IDLE
    push_slide();
    do_op(0, 1, 0, 16'h0000, 16'd0);
    wait_valid("t2", 5);
    check_win("t2");
    check("t2_row2_const", 32'(cache[2]), 32'h212223);
    sync();
    do_op(0, 0, 1, 16'h0000, 16'd0);
    @(negedge clk);
    check("t2_ack_valid", 32'(valid), 32'd0);
    check("t2_ack_busy", 32'(busy), 32'd0);
    sync();

    // Slide in IDLE must not start anything
    do_op(0, 1, 0, 16'h0000, 16'd0);
    repeat (3) @(negedge clk);
    check("idle_slide_valid", 32'(valid), 32'd0);
    check("idle_slide_busy", 32'(busy), 32'd0);
    sync();

    // Address wrap
    push_full(16'hFFFE, 16'd1, 9);
    do_op(1, 0, 0, 16'hFFFE, 16'd1);
    wait_valid("t3", 11);
    check_win("t3");
    check("t3_row0_const", 32'(cache[0]), 32'hFEFF00);
    sync();

    // Start re-pulsed mid-load is ignored
    push_full(16'h0100, 16'd16, 9);
    do_op(1, 0, 0, 16'h0100, 16'd16);
    fork
      wait_valid("t4", 11);
      begin
        repeat (2) @(posedge clk);
        #1 start = 1'b1; base_addr = 16'h0300; stride = 16'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    check_win("t4");
    sync();

    // Reset in cycle 5 of a load
    push_full(16'h0100, 16'd16, 5);
    do_op(1, 0, 0, 16'h0100, 16'd16);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int r = 0; r < 3; r++) m_win[r] = '0;
    @(negedge clk);
    check("t5_mem_rd", 32'(mem_rd), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_valid", 32'(valid), 32'd0);
    check_win("t5_c6");
    @(negedge clk);
    check_win("t5_c7");
    sync();
    push_full(16'h0040, 16'd8, 9);
    do_op(1, 0, 0, 16'h0040, 16'd8);
    wait_valid("t5b", 11);
    check_win("t5b");
    sync();

    // stride 0 repeats one row
    push_full(16'h0005, 16'd0, 9);
    do_op(1, 0, 0, 16'h0005, 16'd0);
    wait_valid("s0", 11);
    check_win("s0");
    sync();

    // ack+start+slide together: start wins
    push_full(16'h0200, 16'd16, 9);
    do_op(1, 1, 1, 16'h0200, 16'd16);
    wait_valid("t6", 11);
    check_win("t6");
    sync();

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
